// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single shared combinational ALU: IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARB_RR_EN for round-robin tie-break; the default build uses fixed priority to port 0.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_A,
  input  logic [W-1:0] req0_B,
  input  logic [5:0]   req0_ALUFun,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_A,
  input  logic [W-1:0] req1_B,
  input  logic [5:0]   req1_ALUFun,
  output logic [W-1:0] alu_A,
  output logic [W-1:0] alu_B,
  output logic [5:0]   alu_ALUFun,
  input  logic [W-1:0] alu_S,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_S,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_S,
  input  logic         rsp1_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         lsp_q, lsp_d;
  logic         owner_q, owner_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [5:0]   fun_q, fun_d;
  logic [W-1:0] rsp0_s_q, rsp0_s_d;
  logic [W-1:0] rsp1_s_q, rsp1_s_d;
  logic         grant0, grant1;
  logic         owner_ready;

  // Grant is purely combinational from the valids and the last-served pointer.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      grant0 = lsp_q;
      grant1 = ~lsp_q;
`else
      grant0 = 1'b1;
`endif
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  // NOTE: every *_d gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_d  = state_q;
    lsp_d    = lsp_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    fun_d    = fun_q;
    rsp0_s_d = rsp0_s_q;
    rsp1_s_d = rsp1_s_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d = EXEC;
          owner_d = grant1;
          a_d     = grant1 ? req1_A      : req0_A;
          b_d     = grant1 ? req1_B      : req0_B;
          fun_d   = grant1 ? req1_ALUFun : req0_ALUFun;
        end
      end
      EXEC: begin
        state_d = RESP;
        // Each port keeps its own result register so the idle port's rsp_S never moves.
        if (owner_q) rsp1_s_d = alu_S;
        else         rsp0_s_d = alu_S;
      end
      RESP: begin
        if (owner_ready) begin
          state_d = IDLE;
          lsp_d   = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and clears
  // every register (operands included) so the ALU sees zeros straight after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      lsp_q    <= 1'b1;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      rsp0_s_q <= '0;
      rsp1_s_q <= '0;
    end else begin
      state_q  <= state_d;
      lsp_q    <= lsp_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fun_q    <= fun_d;
      rsp0_s_q <= rsp0_s_d;
      rsp1_s_q <= rsp1_s_d;
    end
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && grant0 && !reset;
    req1_ready = (state_q == IDLE) && grant1 && !reset;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) && owner_q;
    rsp0_S     = rsp0_s_q;
    rsp1_S     = rsp1_s_q;
    alu_A      = a_q;
    alu_B      = b_q;
    alu_ALUFun = fun_q;
  end

endmodule
